// File: rtl/fifo_rd_arbiter.sv
// Read-side controller of the async FIFO: read pointer (binary and Gray), empty flag
// and fill count, plus round-robin sharing of the single read port with bounded bursts.
module fifo_rd_arbiter #(
    parameter int ASIZE = 4,
    parameter int NREQ  = 2,
    parameter int BURST = 4
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic [ASIZE:0]   rq2_wptr,
    output logic [ASIZE:0]   rptr,
    output logic [ASIZE-1:0] raddr,
    output logic             rempty,
    output logic [ASIZE:0]   rcount,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  rd_en,
    output logic [NREQ-1:0]  grant,
    output logic             pop
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q, state_d;
    logic [ASIZE:0]  rbin_q, rbin_d;
    logic [ASIZE:0]  rptr_q, rptr_d;
    logic            rempty_q, rempty_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IW-1:0]   last_grant_q, last_grant_d;
    logic [CW-1:0]   burst_cnt_q, burst_cnt_d;
    logic [IW-1:0]   sel;

    function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
        logic [ASIZE:0] b;
        b[ASIZE] = g[ASIZE];
        for (int i = ASIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // First requester above the last winner, otherwise wrap to the lowest requester.
    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IW-1:0]   last);
        logic [IW-1:0] s;
        logic          found;
        s     = '0;
        found = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (!found && r[j] && (IW'(j) > last)) begin
                found = 1'b1;
                s     = IW'(j);
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!found && r[j]) begin
                found = 1'b1;
                s     = IW'(j);
            end
        end
        return s;
    endfunction

    assign pop = (|(rd_en & grant_q)) & ~rempty_q;

    always_comb begin
        rbin_d   = rbin_q + {{ASIZE{1'b0}}, pop};
        rptr_d   = (rbin_d >> 1) ^ rbin_d;
        rempty_d = (rptr_d == rq2_wptr);
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        sel          = rr_pick(req, last_grant_q);
        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (!rempty_q && (|req)) begin
                    state_d      = GRANT;
                    grant_d      = {{(NREQ-1){1'b0}}, 1'b1} << sel;
                    last_grant_d = sel;
                    burst_cnt_d  = '0;
                end
            end
            GRANT: begin
                // Release on burst limit, owner dropping req, or FIFO going empty.
                if ((pop && (burst_cnt_q == CW'(BURST - 1))) ||
                    !(|(req & grant_q)) || rempty_d) begin
                    state_d     = IDLE;
                    grant_d     = '0;
                    burst_cnt_d = '0;
                end else if (pop) begin
                    burst_cnt_d = burst_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_q      <= IDLE;
            rbin_q       <= '0;
            rptr_q       <= '0;
            rempty_q     <= 1'b1;
            grant_q      <= '0;
            last_grant_q <= IW'(NREQ - 1);
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            rbin_q       <= rbin_d;
            rptr_q       <= rptr_d;
            rempty_q     <= rempty_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    assign rptr   = rptr_q;
    assign raddr  = rbin_q[ASIZE-1:0];
    assign rempty = rempty_q;
    assign rcount = gray2bin(rq2_wptr) - rbin_q;
    assign grant  = grant_q;

endmodule
